// File: rtl/weight_loader.sv
// weight_loader: fetches up to NUM_PE weights from SRAM and strobes them one-hot into the PE weight buffers.
module weight_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PE     = 9,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [$clog2(NUM_PE+1)-1:0]   num_wgt,
    input  logic                          hold,
    output logic                          mem_rd_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data,
    output logic [NUM_PE-1:0]             set_wgt,
    output logic [DATA_WIDTH-1:0]         wgt_out,
    output logic                          busy,
    output logic                          done
);
    localparam int CW = $clog2(NUM_PE+1);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] n_q, n_clamp, iss_cnt, ret_cnt;
    logic rd_v, issue, last_out;
    assign n_clamp  = (num_wgt > CW'(NUM_PE)) ? CW'(NUM_PE) : num_wgt;
    assign last_out = set_wgt[n_q - 1'b1];
    // read 0 is issued straight from IDLE so it lands in the cycle after start
    assign issue = (state == IDLE) ? (start && n_clamp != '0)
                                   : (state == READ && iss_cnt < n_q && !hold);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (n_clamp == '0) ? DONE : READ;
            READ:    if (iss_cnt == n_q) state_nxt = DRAIN;
            DRAIN:   if (last_out) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == READ) || (state == DRAIN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rd_v      <= 1'b0;
            set_wgt   <= '0;
            wgt_out   <= '0;
            n_q       <= '0;
            iss_cnt   <= '0;
            ret_cnt   <= '0;
        end else begin
            mem_rd_en <= issue;
            rd_v      <= mem_rd_en;
            set_wgt   <= rd_v ? NUM_PE'(1) << ret_cnt : '0;
            if (rd_v) begin
                wgt_out <= mem_rd_data;
                ret_cnt <= ret_cnt + 1'b1;
            end
            if (state == IDLE && start) begin
                n_q     <= n_clamp;
                ret_cnt <= '0;
            end
            if (issue) begin
                mem_addr <= (state == IDLE) ? base_addr : mem_addr + 1'b1;
                iss_cnt  <= (state == IDLE) ? CW'(1) : iss_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed loads with a queue scoreboard checked by an independent output monitor.
module tb_weight_loader;
    logic clk = 0, rst = 1, start = 0, hold = 0;
    logic [11:0] base_addr = '0;
    logic [3:0] num_wgt = '0;
    logic mem_rd_en;
    logic [11:0] mem_addr;
    logic [7:0] mem_rd_data = '0;
    logic [8:0] set_wgt;
    logic [7:0] wgt_out;
    logic busy, done;
    logic [7:0] sram [4096];
    int cyc = 0, c0 = 0, vectors = 0, errs = 0;
    typedef struct {int idx; int data; int at;} set_t;
    set_t exp_set[$];
    int exp_addr[$];
    int exp_done[$];

    weight_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_wgt(num_wgt),
        .hold(hold), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .set_wgt(set_wgt), .wgt_out(wgt_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM model with one cycle of read latency
    always @(posedge clk) begin
        cyc++;
        if (mem_rd_en) mem_rd_data <= sram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle C%0d)", name, act, exp, cyc - c0);
        end
    endtask

    always @(negedge clk) begin
        int rel;
        set_t e;
        rel = cyc - c0;
        if (mem_rd_en) begin
            if (exp_addr.size() == 0) chk("unexpected_read", 32'(mem_addr), 32'hFFFF_FFFF);
            else chk("rd_addr", 32'(mem_addr), exp_addr.pop_front());
        end
        if (set_wgt != '0) begin
            if (exp_set.size() == 0) chk("unexpected_set_wgt", 32'(set_wgt), 0);
            else begin
                e = exp_set.pop_front();
                chk("set_wgt", 32'(set_wgt), 32'(1) << e.idx);
                chk("wgt_out", 32'(wgt_out), e.data);
                chk("busy_during_load", 32'(busy), 1);
                if (e.at >= 0) chk("set_wgt_cycle", rel, e.at);
            end
        end
        if (done) begin
            if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                chk("done_cycle", rel, exp_done.pop_front());
                chk("busy_in_done", 32'(busy), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drained(input string name);
        chk(name, exp_set.size() + exp_addr.size() + exp_done.size(), 0);
    endtask

    // issues start in the current cycle (C0); tu = number of leading pulses with fixed timing
    task automatic load(input logic [11:0] b, input int n, input int dc, input int tu);
        int nn;
        nn = (n > 9) ? 9 : n;
        start = 1;
        base_addr = b;
        num_wgt = 4'(n);
        c0 = cyc;
        for (int i = 0; i < nn; i++) begin
            exp_set.push_back('{i, int'(sram[12'(b + 12'(i))]), (i < tu) ? 3 + i : -1});
            exp_addr.push_back(int'(12'(b + 12'(i))));
        end
        exp_done.push_back(dc);
        tick();
        start = 0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 9; i++) sram[16 + i] = 8'(i + 1);
        idle(3);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_set_wgt", 32'(set_wgt), 0);
        chk("rst_wgt_out", 32'(wgt_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 0;
        tick();
        // full nine-weight load
        load(12'h010, 9, 12, 9);
        idle(14);
        drained("t1_drained");
        // hold across C3..C5 stretches the load by three cycles
        load(12'h010, 9, 15, 2);
        idle(2);
        hold = 1;
        idle(3);
        hold = 0;
        idle(14);
        drained("t2_drained");
        // empty load and clamped load
        load(12'h100, 0, 1, 0);
        idle(5);
        drained("t3_zero_drained");
        load(12'h010, 15, 12, 9);
        idle(14);
        drained("t3_clamp_drained");
        // start mid-load and in the done cycle are ignored, then back-to-back load
        load(12'h010, 9, 12, 9);
        idle(4);
        start = 1;
        tick();
        start = 0;
        idle(6);
        start = 1;
        base_addr = 12'h020;
        num_wgt = 4'd5;
        tick();
        load(12'h020, 5, 8, 5);
        idle(12);
        drained("t4_drained");
        // reset in C6 aborts the load
        load(12'h010, 9, 12, 9);
        idle(5);
        rst = 1;
        tick();
        rst = 0;
        chk("t5_sets_before_rst", exp_set.size(), 5);
        exp_set.delete();
        exp_addr.delete();
        exp_done.delete();
        @(negedge clk);
        chk("t5_mem_rd_en", 32'(mem_rd_en), 0);
        chk("t5_set_wgt", 32'(set_wgt), 0);
        chk("t5_wgt_out", 32'(wgt_out), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        idle(15);
        load(12'h010, 9, 12, 9);
        idle(14);
        drained("t5_restart_drained");
        // address wrap
        load(12'hFFE, 4, 7, 4);
        idle(10);
        drained("t6_drained");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
